// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow resolution: detects mispredicts, runs the redirect
// handshake to fetch, holds a front-end flush window and emits predictor updates.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_cf,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_stall,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             flush_front,
    output logic             bp_upd_valid,
    output logic [XLEN-1:0]  bp_upd_pc,
    output logic [XLEN-1:0]  bp_upd_target,
    output logic             bp_upd_taken,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [FC_W-1:0]   flush_cnt;
    logic              resolve;
    logic              mispredict;
    logic [XLEN-1:0]   fix_pc;

    // A not-taken, predicted-not-taken branch never compares targets.
    assign resolve    = (state == IDLE) & ex_valid & ex_is_cf;
    assign mispredict = (ex_taken != ex_pred_taken) |
                        (ex_taken & (ex_target != ex_pred_target));
    assign fix_pc     = ex_taken ? ex_target : ex_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (resolve && mispredict) state_nxt = REDIRECT;
            REDIRECT: if (redir_ready)           state_nxt = FLUSH;
            FLUSH:    if (flush_cnt == '0)       state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Down-counter: the cycle it reads zero is the final FLUSH cycle.
    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt <= '0;
        else if (state == REDIRECT && redir_ready)
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        else if (state == FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            redir_pc <= '0;
        else if (resolve && mispredict)
            redir_pc <= fix_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_upd_valid  <= 1'b0;
            bp_upd_pc     <= '0;
            bp_upd_target <= '0;
            bp_upd_taken  <= 1'b0;
        end else begin
            bp_upd_valid <= resolve;
            if (resolve) begin
                bp_upd_pc     <= ex_pc;
                bp_upd_target <= ex_target;
                bp_upd_taken  <= ex_taken;
            end
        end
    end

    // Saturating statistics, never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (resolve) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 1'b1;
            if (mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

    assign redir_valid = (state == REDIRECT);
    assign flush_front = (state != IDLE);
    assign ex_stall    = (state != IDLE);

endmodule
